// File: rtl/rbm_sample_averager.sv
// Averages per-lane hidden-unit samples over 2**AVG_LOG2 accepted cycles and emits the packed mean.
// Define RBM_AVG_ROUND_EN to round half up instead of truncating.
module rbm_sample_averager #(
    parameter int out_dim          = 5,
    parameter int output_bitlength = 12,
    parameter int AVG_LOG2         = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [out_dim*output_bitlength-1:0] sample_in,
    input  logic                                 sample_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 avg_valid,
    output logic [out_dim*output_bitlength-1:0] avg_out
);

    localparam int W     = output_bitlength;
    localparam int AW    = output_bitlength + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int OUT_W = out_dim * output_bitlength;
    localparam int N     = 1 << AVG_LOG2;

    // Handshake: a sample is consumed on any rising edge where state is ACCUM,
    // sample_valid=1 and start=0; start always wins and opens a fresh window.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     acc_q [out_dim];
    logic [AW-1:0]     acc_d [out_dim];
    logic [OUT_W-1:0]  avg_q, avg_d;
    logic              avg_valid_q, avg_valid_d;

    logic [AW-1:0]     acc_sum [out_dim];
    logic [OUT_W-1:0]  avg_next;

    always_comb begin
        // Mean is taken from the sum that already includes the current sample.
        avg_next = '0;
        for (int i = 0; i < out_dim; i++) begin
            acc_sum[i] = acc_q[i] + AW'(sample_in[i*W +: W]);
`ifdef RBM_AVG_ROUND_EN
            avg_next[i*W +: W] = W'((acc_sum[i] + AW'(N / 2)) >> AVG_LOG2);
`else
            avg_next[i*W +: W] = W'(acc_sum[i] >> AVG_LOG2);
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ACCUM;
                    count_d     = '0;
                    avg_d       = '0;
                    avg_valid_d = 1'b0;
                    for (int i = 0; i < out_dim; i++) acc_d[i] = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (start) begin
                    count_d     = '0;
                    avg_d       = '0;
                    avg_valid_d = 1'b0;
                    for (int i = 0; i < out_dim; i++) acc_d[i] = '0;
                end else if (sample_valid) begin
                    acc_d   = acc_sum;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N - 1)) begin
                        state_d     = S_DONE;
                        avg_d       = avg_next;
                        avg_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            for (int i = 0; i < out_dim; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            for (int i = 0; i < out_dim; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign busy      = (state_q == S_ACCUM);
    assign done      = (state_q == S_DONE);
    assign avg_valid = avg_valid_q;
    assign avg_out   = avg_q;

endmodule

// File: tb/tb_rbm_sample_averager.sv
// Scoreboard bench for rbm_sample_averager: directed scenarios plus randomized windows
// checked against a sum-and-divide reference model.
module tb_rbm_sample_averager;

    localparam int OD = 5;
    localparam int W  = 12;
    localparam int L  = 4;
    localparam int N  = 16;
    localparam int OW = OD * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [OW-1:0] sample_in;
    logic          sample_valid;
    logic          busy;
    logic          done;
    logic          avg_valid;
    logic [OW-1:0] avg_out;

    int total = 0;
    int bad   = 0;
    int dones_seen = 0;
    int dones_exp  = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] win_q[$];
    logic          in_window = 1'b0;
    logic [OW-1:0] last_exp = '0;

    rbm_sample_averager #(
        .out_dim(OD), .output_bitlength(W), .AVG_LOG2(L)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy), .done(done), .avg_valid(avg_valid), .avg_out(avg_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: arithmetic mean of the accepted samples per lane.
    function automatic logic [OW-1:0] model_mean();
        logic [OW-1:0] r;
        int unsigned   sum;
        int unsigned   m;
        r = '0;
        for (int lane = 0; lane < OD; lane++) begin
            sum = 0;
            foreach (win_q[k]) sum += int'(win_q[k][lane*W +: W]);
`ifdef RBM_AVG_ROUND_EN
            m = (sum + N / 2) / N;
`else
            m = sum / N;
`endif
            r[lane*W +: W] = m[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] rand_vec();
        logic [OW-1:0] v;
        for (int i = 0; i < OD; i++) v[i*W +: W] = W'($urandom_range(0, 4095));
        return v;
    endfunction

    function automatic logic [OW-1:0] splat(input logic [W-1:0] x);
        logic [OW-1:0] v;
        for (int i = 0; i < OD; i++) v[i*W +: W] = x;
        return v;
    endfunction

    // Inputs are applied after an edge; returns 1 time unit after the edge that consumed them.
    task automatic step(input logic st, input logic sv, input logic [OW-1:0] d);
        start        = st;
        sample_valid = sv;
        sample_in    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic sv);
        step(1'b1, sv, rand_vec());
        win_q.delete();
        in_window = 1'b1;
    endtask

    task automatic do_sample(input logic [OW-1:0] d, input int gaps);
        for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, rand_vec());
        step(1'b0, 1'b1, d);
        if (in_window) begin
            win_q.push_back(d);
            if (win_q.size() == N) begin
                last_exp = model_mean();
                exp_q.push_back(last_exp);
                dones_exp++;
                win_q.delete();
                in_window = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_vec());
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clock) begin
        if (!reset && done) begin
            dones_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                logic [OW-1:0] e;
                e = exp_q.pop_front();
                total++;
                if (avg_out !== e) begin
                    bad++;
                    $display("FAIL avg_out: got %h expected %h", avg_out, e);
                end
                if (avg_valid !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_flags: got avg_valid=%b busy=%b expected 1 0", avg_valid, busy);
                end
            end
        end
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_in = '0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_avg_valid", 64'(avg_valid), 64'd0);
        check("rst_avg_out", 64'(avg_out), 64'd0);
        reset = 1'b0;
        idle(2);

        // 1: constant 0x100, no gaps; latency and done pulse width
        do_start(1'b0);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        for (int k = 0; k < N; k++) do_sample(splat(12'h100), 0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_avg_valid", 64'(avg_valid), 64'd1);
        check("t1_avg_out", 64'(avg_out), 64'(splat(12'h100)));
        idle(1);
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_avg_valid_held", 64'(avg_valid), 64'd1);

        // 2: lane 0 alternates 0x000/0xFFF
        do_start(1'b1);
        check("t2_avg_valid_cleared", 64'(avg_valid), 64'd0);
        check("t2_avg_out_cleared", 64'(avg_out), 64'd0);
        for (int k = 0; k < N; k++) begin
            logic [OW-1:0] d;
            d = '0;
            d[W-1:0] = (k % 2 == 1) ? 12'hFFF : 12'h000;
            do_sample(d, 0);
        end
`ifdef RBM_AVG_ROUND_EN
        check("t2_lane0", 64'(avg_out), 64'h800);
`else
        check("t2_lane0", 64'(avg_out), 64'h7FF);
`endif
        idle(2);

        // 3: all lanes 0xFFF with pattern 1,0,0
        do_start(1'b0);
        for (int k = 0; k < N; k++) begin
            do_sample(splat(12'hFFF), 0);
            if (k < N - 1) begin
                step(1'b0, 1'b0, rand_vec());
                check("t3_busy_gap", 64'(busy), 64'd1);
                check("t3_no_early_done", 64'(done), 64'd0);
                step(1'b0, 1'b0, rand_vec());
            end
        end
        check("t3_done", 64'(done), 64'd1);
        check("t3_avg_out", 64'(avg_out), 64'(splat(12'hFFF)));
        idle(2);

        // 4: restart mid-window, exactly one done
        d0 = dones_seen;
        do_start(1'b0);
        for (int k = 0; k < 7; k++) do_sample(splat(12'h050), 0);
        do_start(1'b0);
        for (int k = 0; k < N; k++) do_sample(splat(12'h020), 0);
        idle(3);
        check("t4_one_done", 64'(dones_seen - d0), 64'd1);
        check("t4_avg_out", 64'(avg_out), 64'(splat(12'h020)));

        // 5: reset mid-window
        do_start(1'b0);
        for (int k = 0; k < 10; k++) do_sample(rand_vec(), 0);
        reset = 1'b1;
        step(1'b0, 1'b1, rand_vec());
        reset = 1'b0;
        win_q.delete();
        in_window = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_avg_valid", 64'(avg_valid), 64'd0);
        check("t5_avg_out", 64'(avg_out), 64'd0);
        do_start(1'b0);
        for (int k = 0; k < N; k++) do_sample(rand_vec(), 0);
        idle(3);
        check("t5_avg_held", 64'(avg_out), 64'(last_exp));

        // 6: start together with the 16th sample
        do_start(1'b0);
        for (int k = 0; k < N - 1; k++) do_sample(rand_vec(), 0);
        do_start(1'b1);
        check("t6_no_done", 64'(done), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        idle(1);
        check("t6_still_no_done", 64'(done), 64'd0);
        for (int k = 0; k < N; k++) do_sample(rand_vec(), $urandom_range(0, 1));
        idle(2);

        // Randomized windows: gaps, restarts, starts in the DONE cycle, stray samples
        for (int w = 0; w < 20; w++) begin
            do_start(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                int pre;
                pre = $urandom_range(1, N - 1);
                for (int k = 0; k < pre; k++) do_sample(rand_vec(), $urandom_range(0, 2));
                do_start(1'($urandom_range(0, 1)));
            end
            for (int k = 0; k < N; k++) do_sample(rand_vec(), $urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) begin
                int n_idle;
                n_idle = $urandom_range(1, 3);
                for (int i = 0; i < n_idle; i++) do_sample(rand_vec(), 0);
                check("rnd_avg_held", 64'(avg_out), 64'(last_exp));
                check("rnd_avg_valid_held", 64'(avg_valid), 64'd1);
            end
        end
        idle(4);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(dones_seen), 64'(dones_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
